// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller: tracks in-flight register writers per pipeline stage
// and derives per-port forwarding selects plus the decode stall for the ID stage.
module hazard_scoreboard #(
  parameter  int unsigned NREG  = 32,
  parameter  int unsigned NRD   = 2,
  parameter  int unsigned DEPTH = 3,
  parameter  int unsigned CW    = 16,
  localparam int unsigned AW    = $clog2(NREG),
  localparam int unsigned SW    = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic              issue_we_i,
  input  logic [AW-1:0]     issue_rd_i,
  input  logic [SW-1:0]     issue_rdy_stage_i,
  input  logic              flush_i,
  input  logic [NRD-1:0]    src_used_i,
  input  logic [NRD*AW-1:0] src_addr_i,
  output logic [NRD*SW-1:0] fwd_sel_o,
  output logic              stall_o,
  output logic [CW-1:0]     stall_cnt_o
);

  // e[k] describes the instruction k cycles past issue
  logic          v_q   [1:DEPTH];
  logic          we_q  [1:DEPTH];
  logic [AW-1:0] rd_q  [1:DEPTH];
  logic [SW-1:0] rdy_q [1:DEPTH];

  logic [SW-1:0]  rdy_norm;
  logic [NRD-1:0] stall_req;
  logic [NRD-1:0] found;
  logic           load;

  // Clamp the ready stage into 1..DEPTH before it enters the scoreboard
  always_comb begin
    rdy_norm = issue_rdy_stage_i;
    if (issue_rdy_stage_i == '0) begin
      rdy_norm = SW'(1);
    end else if (32'(issue_rdy_stage_i) > DEPTH) begin
      rdy_norm = SW'(DEPTH);
    end
  end

  assign load = issue_valid_i & ~stall_o & ~flush_i;

  // Downstream stages never stall, so the scoreboard shifts every cycle
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        v_q[k]   <= 1'b0;
        we_q[k]  <= 1'b0;
        rd_q[k]  <= '0;
        rdy_q[k] <= '0;
      end
    end else begin
      v_q[1]   <= load;
      we_q[1]  <= issue_we_i;
      rd_q[1]  <= issue_rd_i;
      rdy_q[1] <= rdy_norm;
      for (int unsigned k = 2; k <= DEPTH; k++) begin
        v_q[k]   <= v_q[k-1];
        we_q[k]  <= we_q[k-1];
        rd_q[k]  <= rd_q[k-1];
        rdy_q[k] <= rdy_q[k-1];
      end
    end
  end

  // Youngest matching writer decides: forward if its result exists, else stall
  always_comb begin
    fwd_sel_o = '0;
    stall_req = '0;
    found     = '0;
    for (int unsigned p = 0; p < NRD; p++) begin
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        if (!found[p] && src_used_i[p] && v_q[k] && we_q[k] &&
            (rd_q[k] == src_addr_i[p*AW +: AW]) && (src_addr_i[p*AW +: AW] != '0)) begin
          found[p] = 1'b1;
          if (SW'(k) >= rdy_q[k]) begin
            fwd_sel_o[p*SW +: SW] = SW'(k);
          end else begin
            stall_req[p] = 1'b1;
          end
        end
      end
    end
  end

  assign stall_o       = (|stall_req) & issue_valid_i & ~flush_i;
  assign issue_ready_o = ~stall_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed hazard scenarios plus randomized traffic,
// checked every cycle against an issue-history model of in-flight writers.
module tb_hazard_scoreboard;

  localparam int NRD   = 2;
  localparam int DEPTH = 3;
  localparam int AW    = 5;
  localparam int SW    = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              issue_valid = 1'b0;
  logic              issue_we = 1'b0;
  logic [AW-1:0]     issue_rd = '0;
  logic [SW-1:0]     issue_rdy = '0;
  logic              flush = 1'b0;
  logic [NRD-1:0]    src_used = '0;
  logic [NRD*AW-1:0] src_addr = '0;

  logic              ready16, ready4, stall16, stall4;
  logic [NRD*SW-1:0] fwd16, fwd4;
  logic [15:0]       cnt16;
  logic [3:0]        cnt4;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREG(32), .NRD(NRD), .DEPTH(DEPTH), .CW(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .issue_valid_i(issue_valid), .issue_ready_o(ready16),
    .issue_we_i(issue_we), .issue_rd_i(issue_rd), .issue_rdy_stage_i(issue_rdy),
    .flush_i(flush), .src_used_i(src_used), .src_addr_i(src_addr),
    .fwd_sel_o(fwd16), .stall_o(stall16), .stall_cnt_o(cnt16)
  );

  hazard_scoreboard #(.NREG(32), .NRD(NRD), .DEPTH(DEPTH), .CW(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .issue_valid_i(issue_valid), .issue_ready_o(ready4),
    .issue_we_i(issue_we), .issue_rd_i(issue_rd), .issue_rdy_stage_i(issue_rdy),
    .flush_i(flush), .src_used_i(src_used), .src_addr_i(src_addr),
    .fwd_sel_o(fwd4), .stall_o(stall4), .stall_cnt_o(cnt4)
  );

  // Model: list of issued writers stamped with their issue cycle
  typedef struct {
    int cyc;
    bit we;
    int rd;
    int rdy;
  } rec_t;

  rec_t q[$];
  int   now    = 0;
  int   nstall = 0;

  function automatic void model_eval(output logic [NRD*SW-1:0] f, output bit st);
    bit sreq = 1'b0;
    f = '0;
    for (int p = 0; p < NRD; p++) begin
      logic [AW-1:0] s;
      int best = 0;
      int brdy = 0;
      int eff;
      s = src_addr[p*AW +: AW];
      if (src_used[p] && s != '0) begin
        foreach (q[i]) begin
          int d = now - q[i].cyc;
          if (d >= 1 && d <= DEPTH && q[i].we && q[i].rd == int'(s) && (best == 0 || d < best)) begin
            best = d;
            brdy = q[i].rdy;
          end
        end
      end
      if (best != 0) begin
        eff = (brdy < 1) ? 1 : ((brdy > DEPTH) ? DEPTH : brdy);
        if (best >= eff) f[p*SW +: SW] = SW'(best);
        else sreq = 1'b1;
      end
    end
    st = sreq && issue_valid && !flush;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge rst_n) begin
    q.delete();
    nstall = 0;
  end

  // Advance the model on each active edge while out of reset
  always @(posedge clk) begin
    logic [NRD*SW-1:0] f;
    bit st;
    if (rst_n) begin
      model_eval(f, st);
      if (st) nstall++;
      if (issue_valid && !st && !flush) begin
        rec_t r;
        r.cyc = now;
        r.we  = issue_we;
        r.rd  = int'(issue_rd);
        r.rdy = int'(issue_rdy);
        q.push_back(r);
      end
      now++;
      while (q.size() > 0 && (now - q[0].cyc) > DEPTH) void'(q.pop_front());
    end
  end

  // Every-cycle comparison of both instances against the model
  always @(negedge clk) begin
    logic [NRD*SW-1:0] f;
    bit st;
    model_eval(f, st);
    chk("fwd_sel",  32'(fwd16),   32'(f));
    chk("stall",    32'(stall16), 32'(st));
    chk("ready",    32'(ready16), 32'(!st));
    chk("cnt16",    32'(cnt16),   (nstall > 65535) ? 32'd65535 : 32'(nstall));
    chk("fwd_sel4", 32'(fwd4),    32'(f));
    chk("stall4",   32'(stall4),  32'(st));
    chk("ready4",   32'(ready4),  32'(!st));
    chk("cnt4",     32'(cnt4),    (nstall > 15) ? 32'd15 : 32'(nstall));
  end

  task automatic drv(input bit v, input bit we, input int rd, input int rdy, input bit fl,
                     input int used, input int s0, input int s1);
    @(posedge clk);
    #2;
    issue_valid = v;
    issue_we    = we;
    issue_rd    = AW'(rd);
    issue_rdy   = SW'(rdy);
    flush       = fl;
    src_used    = NRD'(used);
    src_addr    = {AW'(s1), AW'(s0)};
    @(negedge clk);
    #1;
  endtask

  task automatic rnd();
    drv(($urandom % 4) != 0, ($urandom % 4) != 0, int'($urandom % 8), int'($urandom % 4),
        ($urandom % 8) == 0, int'($urandom % 4), int'($urandom % 8), int'($urandom % 8));
  endtask

  int saved;

  initial begin
    #3;
    chk("rst_stall", 32'(stall16), 32'd0);
    chk("rst_ready", 32'(ready16), 32'd1);
    chk("rst_fwd",   32'(fwd16),   32'd0);
    chk("rst_cnt",   32'(cnt16),   32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) drv(0, 0, 0, 0, 0, 0, 0, 0);

    // ALU chain: forward walks 1, 2, 3 then falls back to register file
    drv(1, 1, 5, 1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 5, 0);
    chk("alu_fwd1", 32'(fwd16[1:0]), 32'd1);
    chk("alu_nostall", 32'(stall16), 32'd0);
    drv(0, 0, 0, 0, 0, 1, 5, 0);
    chk("alu_fwd2", 32'(fwd16[1:0]), 32'd2);
    drv(0, 0, 0, 0, 0, 1, 5, 0);
    chk("alu_fwd3", 32'(fwd16[1:0]), 32'd3);
    drv(0, 0, 0, 0, 0, 1, 5, 0);
    chk("alu_fwd0", 32'(fwd16[1:0]), 32'd0);

    // Load-use: one stall cycle, then forward from stage 2
    drv(1, 1, 8, 2, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 2, 0, 8);
    chk("lu_stall", 32'(stall16), 32'd1);
    chk("lu_ready", 32'(ready16), 32'd0);
    chk("lu_fwd1",  32'(fwd16[3:2]), 32'd0);
    drv(1, 0, 0, 0, 0, 2, 0, 8);
    chk("lu_fwd2",   32'(fwd16[3:2]), 32'd2);
    chk("lu_go",     32'(stall16), 32'd0);
    chk("lu_cnt",    32'(cnt16), 32'd1);

    // Youngest writer wins
    drv(1, 1, 7, 1, 0, 0, 0, 0);
    drv(1, 1, 7, 1, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 3, 7, 7);
    chk("young_p0", 32'(fwd16[1:0]), 32'd1);
    chk("young_p1", 32'(fwd16[3:2]), 32'd1);

    // Register zero never hazards
    drv(1, 1, 0, 2, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 1, 0, 0);
    chk("r0_stall", 32'(stall16), 32'd0);
    chk("r0_fwd",   32'(fwd16[1:0]), 32'd0);

    // Flush squashes issue and masks stall
    drv(1, 1, 9, 1, 1, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 1, 9, 0);
    chk("flush_fwd", 32'(fwd16[1:0]), 32'd0);
    drv(1, 1, 8, 2, 0, 0, 0, 0);
    saved = int'(cnt16);
    drv(1, 0, 0, 0, 1, 2, 0, 8);
    chk("flush_nostall", 32'(stall16), 32'd0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_cnt", 32'(cnt16), 32'(saved));

    // 20 stall cycles: rdy=3 at distance 1 stalls twice
    for (int i = 0; i < 10; i++) begin
      drv(1, 1, 8, 3, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 0, 2, 0, 8);
      drv(1, 0, 0, 0, 0, 2, 0, 8);
      drv(1, 0, 0, 0, 0, 2, 0, 8);
    end
    chk("sat_cnt16", 32'(cnt16), 32'd21);
    chk("sat_cnt4",  32'(cnt4),  32'd15);

    repeat (1500) rnd();

    // Mid-stream reset with three valid writers of r5
    drv(1, 1, 5, 1, 0, 0, 0, 0);
    drv(1, 1, 5, 1, 0, 0, 0, 0);
    drv(1, 1, 5, 1, 0, 1, 5, 0);
    chk("pre_rst_fwd", 32'(fwd16[1:0]), 32'd1);
    @(posedge clk);
    #2;
    issue_valid = 1'b0;
    src_used    = 2'b01;
    src_addr    = {AW'(0), AW'(5)};
    rst_n       = 1'b0;
    #1;
    chk("mrst_fwd",   32'(fwd16), 32'd0);
    chk("mrst_stall", 32'(stall16), 32'd0);
    chk("mrst_cnt",   32'(cnt16), 32'd0);
    #4;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_fwd",   32'(fwd16), 32'd0);
    chk("post_rst_stall", 32'(stall16), 32'd0);
    chk("post_rst_cnt",   32'(cnt16), 32'd0);
    drv(0, 0, 0, 0, 0, 1, 5, 0);
    chk("post_rst_fwd2", 32'(fwd16), 32'd0);

    repeat (300) rnd();
    @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
